// File: rtl/pipeline_pkg.sv
// pipeline_pkg: control-bit positions and shared widths for the five-stage core
package pipeline_pkg;
   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMTOREG = 1;
   localparam int CTL_BRANCH   = 2;
   localparam int CTL_MEMREAD  = 3;
   localparam int CTL_MEMWRITE = 4;
   localparam int CTL_W        = 6;
   localparam int REG_ADDR_W   = 5;
   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
      logic                  addr_err;
   } wb_ctl_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-side inputs and branch/write-back outputs of the MEM stage
interface mem_stage_if import pipeline_pkg::*; #(parameter int Width = 32);
   logic [Width-1:0]      ALUResult;
   logic [Width-1:0]      ReadData2;
   logic [Width-1:0]      adderResult;
   logic                  zero;
   logic [REG_ADDR_W-1:0] rd0;
   logic [CTL_W-1:0]      controlSignal;
   logic                  stall;
   logic                  pcSrc;
   logic [Width-1:0]      branchTarget;
   logic [Width-1:0]      wbReadData;
   logic [Width-1:0]      wbALUResult;
   logic [REG_ADDR_W-1:0] wbRd;
   logic                  wbRegWrite;
   logic                  wbMemtoReg;
   logic                  addrErr;
   modport master (
      output ALUResult, ReadData2, adderResult, zero, rd0, controlSignal, stall,
      input  pcSrc, branchTarget, wbReadData, wbALUResult, wbRd, wbRegWrite, wbMemtoReg, addrErr
   );
   modport slave (
      input  ALUResult, ReadData2, adderResult, zero, rd0, controlSignal, stall,
      output pcSrc, branchTarget, wbReadData, wbALUResult, wbRd, wbRegWrite, wbMemtoReg, addrErr
   );
endinterface

// File: rtl/mem_stage_data_memory.sv
// data_memory: word RAM with read-before-write synchronous read port; array is never reset
module data_memory #(
   parameter int Width = 32,
   parameter int Depth = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_en,
   input  logic                     i_we,
   input  logic                     i_re,
   input  logic [$clog2(Depth)-1:0] i_addr,
   input  logic [Width-1:0]         i_wdata,
   output logic [Width-1:0]         o_rdata
);
   logic [Width-1:0] r_mem [Depth];
   logic [Width-1:0] r_rdata;
   // a store presented while reset is held must not land
   always_ff @(posedge clk or negedge rst_n)
      if (rst_n && i_we) r_mem[i_addr] <= i_wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_rdata <= '0;
      else if (i_en) r_rdata <= i_re ? r_mem[i_addr] : '0;
   assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: branch resolve, data memory access and MEM/WB register
module mem_stage import pipeline_pkg::*; #(
   parameter int Width = 32,
   parameter int Depth = 256
) (
   input logic       clk,
   input logic       rst_n,
   mem_stage_if.slave bus
);
   localparam int AW = $clog2(Depth);
   logic [AW-1:0]    w_idx;
   logic             w_valid, w_rd, w_wr, w_we, w_re, w_unused;
   logic [Width-1:0] w_rdata;
   logic [Width-1:0] r_alu;
   wb_ctl_t          r_wb;
   assign w_idx    = bus.ALUResult[AW+1:2];
   assign w_valid  = bus.ALUResult[1:0] == 2'b00 && bus.ALUResult[Width-1:AW+2] == '0;
   assign w_rd     = bus.controlSignal[CTL_MEMREAD];
   assign w_wr     = bus.controlSignal[CTL_MEMWRITE];
   assign w_we     = w_wr & w_valid & ~bus.stall;
   assign w_re     = w_rd & ~w_wr & w_valid;
   assign w_unused = bus.controlSignal[CTL_W-1];
   assign bus.pcSrc        = bus.controlSignal[CTL_BRANCH] & bus.zero;
   assign bus.branchTarget = bus.adderResult;
   data_memory #(.Width(Width), .Depth(Depth)) u_dmem (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (~bus.stall),
      .i_we   (w_we),
      .i_re   (w_re),
      .i_addr (w_idx),
      .i_wdata(bus.ReadData2),
      .o_rdata(w_rdata)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_alu <= '0;
         r_wb  <= '0;
      end else if (!bus.stall) begin
         r_alu          <= bus.ALUResult;
         r_wb.reg_write <= bus.controlSignal[CTL_REGWRITE] & (bus.rd0 != '0);
         r_wb.mem_to_reg <= bus.controlSignal[CTL_MEMTOREG];
         r_wb.rd        <= bus.rd0;
         r_wb.addr_err  <= (w_rd | w_wr) & ~w_valid;
      end
   assign bus.wbReadData  = w_rdata;
   assign bus.wbALUResult = r_alu;
   assign bus.wbRd        = r_wb.rd;
   assign bus.wbRegWrite  = r_wb.reg_write;
   assign bus.wbMemtoReg  = r_wb.mem_to_reg;
   assign bus.addrErr     = r_wb.addr_err;
endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage (MEM) of the 32-bit five-stage core, directly downstream of the execute stage. It consumes the execute results: ALU result, store data, branch target, zero flag, destination register and the 6-bit control bundle. It also resolves the branch, accesses a word-addressed data memory, and holds the MEM/WB pipeline register that feeds write-back.

## Interface
- `Width`, 32: datapath width.
- `Depth`, 256: data memory depth in words, power of two.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ALUResult`  in  Width  memory byte address or ALU value to write back.
- `ReadData2`  in  Width  store data.
- `adderResult`  in  Width  branch target.
- `zero`  in  1  ALU zero flag.
- `rd0`  in  5  destination register.
- `controlSignal`  in  6  control bits: [0] RegWrite, [1] MemtoReg, [2] Branch, [3] MemRead, [4] MemWrite, [5] reserved (ignored).
- `stall`  in  1  hold the MEM/WB register and suppress the memory write.
- `pcSrc`  out  1  combinational: Branch & zero.
- `branchTarget`  out  Width  combinational copy of `adderResult`.
- `wbReadData`  out  Width  registered memory read data.
- `wbALUResult`  out  Width  registered `ALUResult`.
- `wbRd`  out  5  registered `rd0`.
- `wbRegWrite`, `wbMemtoReg`  out  1 each  registered control bits.
- `addrErr`  out  1  registered; the previous access was out of range or misaligned.

## Operation
- Word index is `ALUResult[log2(Depth)+1:2]`. An access is *valid* only when `ALUResult[1:0]==0` and `ALUResult < 4*Depth`.
- **Store.** A store occurs when MemWrite=1, stall=0 and the access is valid: `mem[idx] <= ReadData2` at the edge. Invalid stores leave memory unchanged.
- **Load.** Loads are synchronous, with read-before-write. When MemRead=1, MemWrite=0 and the access is valid, `wbReadData <= mem[idx]` as it was before that edge. Otherwise `wbReadData <= 0`.
- **Both MemRead and MemWrite set.** This combination is illegal. The write wins and `wbReadData <= 0`.
- **addrErr.** `addrErr <= (MemRead|MemWrite) & !valid` when stall=0.
- **Write-back fields.** `wbALUResult`, `wbRd`, `wbRegWrite` and `wbMemtoReg` load from the inputs each edge while stall=0.
- **Register x0.** `wbRegWrite` is forced to 0 when `rd0==0`.
- **Stall.** When stall=1, all registered outputs and memory hold. `pcSrc` and `branchTarget` still follow the inputs.
- **Reset.** While `rst_n` is low, every registered output is 0. Memory contents are not reset and are not guaranteed.
- **Reset mid-operation.** Asserting reset clears the register immediately (asynchronously). A store presented during reset does not occur. The first edge after deassertion behaves normally.

## Timing
- `pcSrc` and `branchTarget` have zero-cycle combinational latency.
- All wb* outputs and `addrErr` have a latency of 1 cycle: the inputs present at edge N appear after edge N.
- **Store-then-load to the same address in consecutive cycles.** The load at edge N+1 returns the data stored at edge N.
- **Load and store to the same word at the same edge.** This occurs only through the both-set case, which returns 0.
- Stall has no bound on duration. Releasing it resumes with whatever is on the inputs; no replay.

## Structure
- **Shared package `pipeline_pkg`:**
  - control-bit index constants (`CTL_REGWRITE`=0 … `CTL_MEMWRITE`=4);
  - `CTL_W`=6;
  - `REG_ADDR_W`=5.
- **Sub-module `data_memory`:**
  - Depth×Width synchronous RAM with write enable;
  - read-before-write read port, with no reset on the array.
- The top level holds:
  - the valid/index logic;
  - the branch logic;
  - the MEM/WB register.

## Test plan
- **Reset.** `rst_n`=0 with random inputs gives all wb* outputs = 0 and `addrErr`=0. Release `rst_n`, drive RegWrite, `rd0`=5 and `ALUResult`=0x1234. One cycle later `wbRd`=5, `wbALUResult`=0x1234, `wbRegWrite`=1.
- **Store/load.** Store 0xDEADBEEF at address 0x10, then the next cycle load 0x10. `wbReadData`=0xDEADBEEF and `addrErr`=0. A load from 0x14 (never written after a prior store of 0) returns the stored value.
- **Branch.** Branch=1, zero=1, `adderResult`=0x40 gives `pcSrc`=1 and `branchTarget`=0x40 in the same cycle. With zero=0, `pcSrc`=0.
- **Errors.** A store to 0x3 gives `addrErr`=1 next cycle, and a later load of 0x0 shows the old value. A load at 4*Depth gives `wbReadData`=0 and `addrErr`=1.
- **Stall.** Assert stall with MemWrite to 0x20 and data 0x55. The wb* outputs hold for 3 cycles and `mem[8]` is unchanged. After release, the outputs update the next cycle.
- **x0 and reset mid-store.** `rd0`=0 with RegWrite=1 gives `wbRegWrite`=0. Pulse `rst_n` low mid-cycle: the outputs clear immediately without waiting for a clock edge.
